controlador_contagem_5bits: RTL and testbench

Sequencing controller for the 5-bit down-counting datapath: loads a programmable start value, decrements it at a prescaled rate, supports pause/abort, and reports completion through a done/ack handshake with optional auto-reload. Sits between the control panel/host logic and the counter, acting as its sole owner: no other block drives load or enable on the counter.

---
 rtl/controlador_contagem_5bits_pkg.sv | 14 +
 rtl/controlador_contagem_5bits_contador.sv | 37 +++
 rtl/controlador_contagem_5bits.sv | 111 +++++++++++
 tb/tb_controlador_contagem_5bits.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/controlador_contagem_5bits_pkg.sv
// Shared definitions for the countdown sequencing controller and its bench.
// State codes are the values reported on the controller's `state` output.
package controlador_contagem_5bits_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/controlador_contagem_5bits_contador.sv
// WIDTH-bit down counter with synchronous clear, load and enable.
// is_one flags the last step before reaching zero.
module contador_carga_5bits #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             is_one
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Priority: clear > load > enable.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count  = count_q;
    assign is_one = (count_q == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/controlador_contagem_5bits.sv
// Sequencing controller for the 5-bit down counter: prescaled decrement,
// pause/abort, done/ack handshake and optional auto-reload.
module controlador_contagem_5bits
    import controlador_contagem_5bits_pkg::*;
#(
    parameter int WIDTH        = 5,
    parameter int PRESC_W      = 4,
    parameter int DEFAULT_LOAD = 16
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
    input  logic               ack,
    input  logic               auto_reload,
    input  logic [WIDTH-1:0]   reload_val,
    input  logic [PRESC_W-1:0] prescale,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] state
);

    localparam logic [WIDTH-1:0] DEF_LOAD = WIDTH'(DEFAULT_LOAD);

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               cnt_clr, cnt_load, cnt_en, cnt_is_one;
    logic [WIDTH-1:0]   eff_val;
    logic               tick;

    assign eff_val = (reload_val == '0) ? DEF_LOAD : reload_val;
    // >= keeps the prescaler from running past a prescale value lowered mid-count.
    assign tick    = (presc_q >= prescale);

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    presc_d  = '0;
                    cnt_load = 1'b1;
                end
            end
            S_RUN, S_PAUSE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                    cnt_clr = 1'b1;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    // Leaving PAUSE counts as a RUN edge so each pause cycle costs exactly one cycle.
                    presc_d = '0;
                    cnt_en  = 1'b1;
                    state_d = cnt_is_one ? S_DONE : S_RUN;
                end else begin
                    presc_d = presc_q + 1'b1;
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                    cnt_clr = 1'b1;
                end else if (start || auto_reload) begin
                    state_d  = S_RUN;
                    presc_d  = '0;
                    cnt_load = 1'b1;
                end else if (ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= S_IDLE;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
        end
    end

    contador_carga_5bits #(
        .WIDTH(WIDTH)
    ) u_contador (
        .clk     (clk),
        .clear   (clear | cnt_clr),
        .load    (cnt_load),
        .en      (cnt_en),
        .load_val(eff_val),
        .count   (count),
        .is_one  (cnt_is_one)
    );

    assign state = state_q;
    assign busy  = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_controlador_contagem_5bits.sv
// Directed bench for controlador_contagem_5bits: each step queues the expected
// {done, busy, state, count} and checks it one edge later.
module tb_controlador_contagem_5bits;
    import controlador_contagem_5bits_pkg::*;

    localparam int W = 9;

    logic       clk = 1'b0;
    logic       clear, start, pause, abort, ack, auto_reload;
    logic [4:0] reload_val;
    logic [3:0] prescale;
    logic [4:0] count;
    logic       busy, done;
    logic [1:0] state;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    controlador_contagem_5bits dut (
        .clk        (clk),
        .clear      (clear),
        .start      (start),
        .pause      (pause),
        .abort      (abort),
        .ack        (ack),
        .auto_reload(auto_reload),
        .reload_val (reload_val),
        .prescale   (prescale),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Queue the expected outputs, clock one edge, then compare away from the edge.
    task automatic cyc(input string tag, input logic [1:0] st, input logic [4:0] cnt);
        logic [W-1:0] exp_v;
        logic [W-1:0] obs_v;
        exp_q.push_back({st == 2'd3, (st == 2'd1) || (st == 2'd2), st, cnt});
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        obs_v = {done, busy, state, count};
        n_checks++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed done=%0b busy=%0b state=%0d count=%0d expected done=%0b busy=%0b state=%0d count=%0d",
                   tag, obs_v[8], obs_v[7], obs_v[6:5], obs_v[4:0],
                   exp_v[8], exp_v[7], exp_v[6:5], exp_v[4:0]);
        end
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; ack = 1'b0;
        auto_reload = 1'b0; reload_val = 5'd0; prescale = 4'd0;
        cyc("reset", S_IDLE, 5'd0);
        cyc("reset_hold", S_IDLE, 5'd0);
        clear = 1'b0;
        cyc("idle", S_IDLE, 5'd0);

        // Basic count of 3 at full rate.
        reload_val = 5'd3; start = 1'b1;
        cyc("basic_load", S_RUN, 5'd3);
        start = 1'b0;
        cyc("basic_2", S_RUN, 5'd2);
        cyc("basic_1", S_RUN, 5'd1);
        cyc("basic_done", S_DONE, 5'd0);
        cyc("basic_hold", S_DONE, 5'd0);
        ack = 1'b1;
        cyc("basic_ack", S_IDLE, 5'd0);
        ack = 1'b0;

        // Default load of 16 with prescale 3: 64 cycles to done.
        reload_val = 5'd0; prescale = 4'd3; start = 1'b1;
        cyc("dflt_load", S_RUN, 5'd16);
        start = 1'b0;
        for (int v = 16; v >= 1; v--) begin
            for (int k = 0; k < 3; k++) cyc("dflt_wait", S_RUN, 5'(v));
            if (v > 1) cyc("dflt_tick", S_RUN, 5'(v - 1));
            else       cyc("dflt_done", S_DONE, 5'd0);
        end
        cyc("dflt_nowrap", S_DONE, 5'd0);
        ack = 1'b1;
        cyc("dflt_ack", S_IDLE, 5'd0);
        ack = 1'b0;

        // Pause for 6 cycles with count = 4: done moves from 10 to 16 cycles.
        reload_val = 5'd5; prescale = 4'd1; start = 1'b1;
        cyc("pause_load", S_RUN, 5'd5);
        start = 1'b0;
        cyc("pause_r5", S_RUN, 5'd5);
        cyc("pause_r4a", S_RUN, 5'd4);
        cyc("pause_r4b", S_RUN, 5'd4);
        pause = 1'b1;
        for (int k = 0; k < 6; k++) cyc("pause_hold", S_PAUSE, 5'd4);
        pause = 1'b0;
        cyc("pause_resume", S_RUN, 5'd3);
        cyc("pause_r3", S_RUN, 5'd3);
        cyc("pause_r2a", S_RUN, 5'd2);
        cyc("pause_r2b", S_RUN, 5'd2);
        cyc("pause_r1a", S_RUN, 5'd1);
        cyc("pause_r1b", S_RUN, 5'd1);
        cyc("pause_done", S_DONE, 5'd0);
        ack = 1'b1;
        cyc("pause_ack", S_IDLE, 5'd0);
        ack = 1'b0;

        // Auto-reload: 1-cycle done pulse every 3 cycles.
        auto_reload = 1'b1; reload_val = 5'd2; prescale = 4'd0; start = 1'b1;
        cyc("auto_load", S_RUN, 5'd2);
        start = 1'b0;
        cyc("auto_1a", S_RUN, 5'd1);
        cyc("auto_done_a", S_DONE, 5'd0);
        cyc("auto_reload_a", S_RUN, 5'd2);
        cyc("auto_1b", S_RUN, 5'd1);
        cyc("auto_done_b", S_DONE, 5'd0);
        cyc("auto_reload_b", S_RUN, 5'd2);
        auto_reload = 1'b0;
        cyc("auto_1c", S_RUN, 5'd1);
        cyc("auto_done_c", S_DONE, 5'd0);

        // start + ack in DONE restarts with a fresh load.
        reload_val = 5'd4; start = 1'b1; ack = 1'b1;
        cyc("start_ack_done", S_RUN, 5'd4);
        ack = 1'b0;
        // abort + start in RUN: abort wins.
        abort = 1'b1;
        cyc("abort_start_run", S_IDLE, 5'd0);
        // abort + start in IDLE: start wins.
        cyc("abort_start_idle", S_RUN, 5'd4);
        start = 1'b0;
        // Abort with count = 4; done must never rise afterwards.
        cyc("abort_mid", S_IDLE, 5'd0);
        abort = 1'b0;
        for (int k = 0; k < 4; k++) cyc("abort_idle", S_IDLE, 5'd0);

        // Clear at count = 7; stray ack/start in RUN are ignored.
        reload_val = 5'd9; start = 1'b1;
        cyc("clr_load", S_RUN, 5'd9);
        start = 1'b0; ack = 1'b1;
        cyc("clr_ack_ignored", S_RUN, 5'd8);
        ack = 1'b0; start = 1'b1;
        cyc("clr_start_ignored", S_RUN, 5'd7);
        start = 1'b0; clear = 1'b1;
        cyc("clr_mid", S_IDLE, 5'd0);
        clear = 1'b0;
        cyc("clr_after", S_IDLE, 5'd0);

        // Abort from PAUSE.
        reload_val = 5'd6; start = 1'b1;
        cyc("pabort_load", S_RUN, 5'd6);
        start = 1'b0; pause = 1'b1;
        cyc("pabort_pause", S_PAUSE, 5'd6);
        abort = 1'b1;
        cyc("pabort_abort", S_IDLE, 5'd0);
        abort = 1'b0; pause = 1'b0;
        cyc("pabort_idle", S_IDLE, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
